// File: rtl/pwm_pkg.sv
// Shared definitions for the two-axis PWM link (generator and decoder sides).
package pwm_pkg;

  localparam int W_DEF       = 6;
  localparam int PERIOD_DEF  = 64;
  localparam int TIMEOUT_DEF = 128;
  localparam int DUTY_MAX    = (1 << W_DEF) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } chan_state_e;

endpackage

// File: rtl/pwm_chan_meas.sv
// One PWM receive channel: input synchronizer, rising-edge detect, period and
// high-time counters, and registered duty/valid/error outputs.
module pwm_chan_meas
  import pwm_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PERIOD  = PERIOD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC    = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic         pulse_i,
  output logic [W-1:0] duty_o,
  output logic         valid_o,
  output logic         err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = W + 1;
  localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
  localparam logic [CW-1:0] TO_LAST_C = CW'(TIMEOUT - 1);

  logic              s;
  logic              s_d_q;
  logic              rise;
  chan_state_e       state_q;
  logic [CW-1:0]     per_cnt_q;
  logic [HW-1:0]     hi_cnt_q;
  logic [HW-1:0]     hi_cnt_d;
  logic [W-1:0]      hi_duty;
  logic [W-1:0]      duty_q;
  logic              valid_q;
  logic              err_q;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], pulse_i};
      end
      assign s = sync_q[1];
    end else begin : g_nosync
      assign s = pulse_i;
    end
  endgenerate

  assign rise     = s & ~s_d_q;
  assign hi_cnt_d = (s && (hi_cnt_q != '1)) ? hi_cnt_q + HW'(1) : hi_cnt_q;

  // High time can exceed the duty range only on malformed input; clamp it.
  always_comb begin
    hi_duty = hi_cnt_q[W-1:0];
    if (hi_cnt_q[W]) hi_duty = '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_d_q     <= 1'b0;
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_d_q   <= s;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!enable_i) begin
        state_q   <= IDLE;
        per_cnt_q <= '0;
        hi_cnt_q  <= '0;
      end else if (rise) begin
        // The first edge after IDLE only opens a measurement window.
        if (state_q == MEAS) begin
          if (per_cnt_q == PERIOD_C) begin
            duty_q  <= hi_duty;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        per_cnt_q <= CW'(1);
        hi_cnt_q  <= HW'(1);
        state_q   <= MEAS;
      end else if (per_cnt_q >= TO_LAST_C) begin
        duty_q    <= {W{s}};
        valid_q   <= 1'b1;
        per_cnt_q <= '0;
        hi_cnt_q  <= '0;
        state_q   <= IDLE;
      end else begin
        per_cnt_q <= per_cnt_q + CW'(1);
        hi_cnt_q  <= (state_q == MEAS) ? hi_cnt_d : '0;
      end
    end
  end

  assign duty_o  = duty_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Two-axis PWM receiver: independent X and Y measurement channels sharing
// clock, reset and enable.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PERIOD  = PERIOD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC    = 1
) (
  input  logic         sysclk,
  input  logic         Reset_Sw,
  input  logic         Enable,
  input  logic         Pulse_X,
  input  logic         Pulse_Y,
  output logic [W-1:0] Duty_X,
  output logic [W-1:0] Duty_Y,
  output logic         Valid_X,
  output logic         Valid_Y,
  output logic         Err_X,
  output logic         Err_Y
);

  logic [1:0]   pulse_w;
  logic [1:0]   valid_w;
  logic [1:0]   err_w;
  logic [W-1:0] duty_w [2];

  assign pulse_w = {Pulse_Y, Pulse_X};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      pwm_chan_meas #(
        .W       (W),
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT),
        .SYNC    (SYNC)
      ) u_meas (
        .clk_i    (sysclk),
        .rst_ni   (Reset_Sw),
        .enable_i (Enable),
        .pulse_i  (pulse_w[gi]),
        .duty_o   (duty_w[gi]),
        .valid_o  (valid_w[gi]),
        .err_o    (err_w[gi])
      );
    end
  endgenerate

  assign Duty_X  = duty_w[0];
  assign Duty_Y  = duty_w[1];
  assign Valid_X = valid_w[0];
  assign Valid_Y = valid_w[1];
  assign Err_X   = err_w[0];
  assign Err_Y   = err_w[1];

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: PWM generator per axis plus an elapsed-time /
// level-history reference model, checked every cycle and per scenario.
module tb_pwm_duty_decoder;

  localparam int W    = 6;
  localparam int PER  = 64;
  localparam int TO   = 128;
  localparam int DMAX = 63;

  logic         sysclk   = 1'b0;
  logic         Reset_Sw = 1'b0;
  logic         Enable   = 1'b0;
  logic         Pulse_X  = 1'b0;
  logic         Pulse_Y  = 1'b0;
  logic [W-1:0] Duty_X, Duty_Y;
  logic         Valid_X, Valid_Y, Err_X, Err_Y;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_duty_decoder #(.W(W), .PERIOD(PER), .TIMEOUT(TO), .SYNC(1)) dut (
    .sysclk   (sysclk),
    .Reset_Sw (Reset_Sw),
    .Enable   (Enable),
    .Pulse_X  (Pulse_X),
    .Pulse_Y  (Pulse_Y),
    .Duty_X   (Duty_X),
    .Duty_Y   (Duty_Y),
    .Valid_X  (Valid_X),
    .Valid_Y  (Valid_Y),
    .Err_X    (Err_X),
    .Err_Y    (Err_Y)
  );

  always #5 sysclk = ~sysclk;

  // Generator: mode 0 = PWM, 1 = stuck low, 2 = stuck high.
  int gen_mode [2] = '{1, 1};
  int gen_per  [2] = '{64, 64};
  int gen_hi   [2] = '{0, 0};
  int gen_ph   [2] = '{0, 0};

  // Model: level seen by the decoder lags the pin by two edges; m_last is the
  // edge index from which the current elapsed-time window is measured.
  bit           m_d1 [2], m_d2 [2], m_prev [2], m_armed [2];
  int           m_last [2];
  int           m_j;
  bit           m_hist [2][256];
  logic [W-1:0] exp_duty [2];
  bit           exp_valid [2], exp_err [2];

  task automatic set_pwm(input int c, input int per, input int hi, input int ph);
    gen_mode[c] = 0; gen_per[c] = per; gen_hi[c] = hi; gen_ph[c] = ph;
  endtask

  task automatic set_stuck(input int c, input bit lvl);
    gen_mode[c] = lvl ? 2 : 1;
  endtask

  task automatic model_reset();
    m_j = 0;
    for (int c = 0; c < 2; c++) begin
      m_d1[c] = 0; m_d2[c] = 0; m_prev[c] = 0; m_armed[c] = 0;
      m_last[c] = 0; exp_duty[c] = '0; exp_valid[c] = 0; exp_err[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit raw [2];
    raw[0] = Pulse_X;
    raw[1] = Pulse_Y;
    for (int c = 0; c < 2; c++) begin
      bit v, rise;
      int ones;
      v    = m_d2[c];
      rise = v && !m_prev[c];
      m_hist[c][m_j % 256] = v;
      exp_valid[c] = 0;
      exp_err[c]   = 0;
      if (!Enable) begin
        m_armed[c] = 0;
        m_last[c]  = m_j + 1;
      end else if (rise) begin
        if (m_armed[c]) begin
          if (m_j - m_last[c] == PER) begin
            ones = 0;
            for (int k = m_last[c]; k < m_j; k++) ones += int'(m_hist[c][k % 256]);
            exp_duty[c]  = W'((ones > DMAX) ? DMAX : ones);
            exp_valid[c] = 1;
          end else begin
            exp_err[c] = 1;
          end
        end
        m_armed[c] = 1;
        m_last[c]  = m_j;
      end else if (m_j - m_last[c] >= TO - 1) begin
        exp_duty[c]  = v ? W'(DMAX) : '0;
        exp_valid[c] = 1;
        m_armed[c]   = 0;
        m_last[c]    = m_j + 1;
      end
      m_prev[c] = v;
      m_d2[c]   = m_d1[c];
      m_d1[c]   = raw[c];
    end
    m_j++;
  endtask

  // Drive one cycle of generator output, advance model on the edge, return at negedge.
  task automatic tick();
    bit lvl [2];
    for (int c = 0; c < 2; c++) begin
      case (gen_mode[c])
        1:       lvl[c] = 1'b0;
        2:       lvl[c] = 1'b1;
        default: begin
          lvl[c]    = (gen_ph[c] < gen_hi[c]);
          gen_ph[c] = (gen_ph[c] + 1) % gen_per[c];
        end
      endcase
    end
    Pulse_X = lvl[0];
    Pulse_Y = lvl[1];
    @(posedge sysclk);
    if (Reset_Sw) model_edge();
    else          model_reset();
    @(negedge sysclk);
  endtask

  function automatic logic [15:0] obs_vec();
    return {Duty_X, Duty_Y, Valid_X, Valid_Y, Err_X, Err_Y};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {exp_duty[0], exp_duty[1], exp_valid[0], exp_valid[1], exp_err[0], exp_err[1]};
  endfunction

  task automatic test_reset();
    model_reset();
    set_stuck(0, 0);
    set_stuck(1, 0);
    Reset_Sw = 1'b0;
    Enable   = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (obs_vec() !== 16'h0) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs_vec(), 16'h0);
    end
    #3 Reset_Sw = 1'b1;
    tick();
    n_tests++;
    if (obs_vec() !== 16'h0) begin
      n_fail++; $display("FAIL reset_release got=%h want=%h", obs_vec(), 16'h0);
    end
  endtask

  task automatic test_loopback();
    int nvx = 0, nvy = 0, nerr = 0, last_vx = -1;
    set_pwm(0, PER, 20, 0);
    set_pwm(1, PER, 45, 0);
    for (int cyc = 1; cyc <= PER * 6; cyc++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL loopback_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X) begin
        if (last_vx >= 0 && cyc - last_vx != PER) begin
          n_fail++; $display("FAIL loopback_gap got=%0d want=%0d", cyc - last_vx, PER);
        end
        if (last_vx >= 0) n_tests++;
        last_vx = cyc; nvx++;
      end
      if (Valid_Y) nvy++;
      if (Err_X || Err_Y) nerr++;
    end
    n_tests += 3;
    if (Duty_X !== 6'd20 || Duty_Y !== 6'd45) begin
      n_fail++; $display("FAIL loopback_duty got=%0d/%0d want=20/45", Duty_X, Duty_Y);
    end
    if (nvx < 4 || nvy < 4) begin
      n_fail++; $display("FAIL loopback_count got=%0d/%0d want>=4", nvx, nvy);
    end
    if (nerr != 0) begin
      n_fail++; $display("FAIL loopback_err got=%0d want=0", nerr);
    end
  endtask

  task automatic test_stuck();
    int nvx = 0, first_vx = -1, last_vx = -1;
    Reset_Sw = 1'b0;
    set_stuck(0, 0);
    set_stuck(1, 1);
    tick(); tick();
    #3 Reset_Sw = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stuck_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X) begin
        if (first_vx < 0) first_vx = cyc;
        if (last_vx >= 0) begin
          n_tests++;
          if (cyc - last_vx != TO) begin
            n_fail++; $display("FAIL stuck_repeat got=%0d want=%0d", cyc - last_vx, TO);
          end
        end
        last_vx = cyc; nvx++;
      end
    end
    n_tests += 3;
    if (first_vx < TO || first_vx > TO + 2) begin
      n_fail++; $display("FAIL stuck_first got=%0d want=%0d..%0d", first_vx, TO, TO + 2);
    end
    if (nvx != 2) begin
      n_fail++; $display("FAIL stuck_count got=%0d want=2", nvx);
    end
    if (Duty_X !== 6'd0 || Duty_Y !== 6'd63) begin
      n_fail++; $display("FAIL stuck_duty got=%0d/%0d want=0/63", Duty_X, Duty_Y);
    end
  endtask

  task automatic test_bad_period();
    int nvx = 0, nex = 0;
    set_pwm(0, PER, 33, 0);
    set_pwm(1, PER, 45, 0);
    repeat (PER * 3) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL badper_pre t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (Duty_X !== 6'd33) begin
      n_fail++; $display("FAIL badper_setup got=%0d want=33", Duty_X);
    end
    set_pwm(0, 60, 30, 30);
    repeat (60 * 6) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL badper_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X) nvx++;
      if (Err_X) nex++;
    end
    n_tests += 3;
    if (nvx != 0) begin
      n_fail++; $display("FAIL badper_valid got=%0d want=0", nvx);
    end
    if (nex < 5) begin
      n_fail++; $display("FAIL badper_err got=%0d want>=5", nex);
    end
    if (Duty_X !== 6'd33) begin
      n_fail++; $display("FAIL badper_hold got=%0d want=33", Duty_X);
    end
  endtask

  task automatic test_duty_change();
    bit seen21 = 0;
    set_pwm(0, PER, 20, 0);
    repeat (PER * 2) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL change_settle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
    end
    repeat (PER * 2 + $urandom_range(0, PER - 1)) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL change_pre t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X) begin
        n_tests++;
        if (Duty_X !== 6'd20) begin
          n_fail++; $display("FAIL change_before got=%0d want=20", Duty_X);
        end
      end
    end
    gen_hi[0] = 21;
    repeat (PER * 4) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL change_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X) begin
        n_tests++;
        if (!((Duty_X === 6'd21) || (Duty_X === 6'd20 && !seen21))) begin
          n_fail++; $display("FAIL change_torn got=%0d want=20 then 21", Duty_X);
        end
        if (Duty_X === 6'd21) seen21 = 1;
      end
    end
    n_tests++;
    if (Duty_X !== 6'd21) begin
      n_fail++; $display("FAIL change_final got=%0d want=21", Duty_X);
    end
  endtask

  task automatic test_reset_midperiod();
    int first_vx = -1;
    repeat (100 + $urandom_range(0, PER - 1)) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midrst_pre t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
    end
    #2 Reset_Sw = 1'b0;
    #1;
    n_tests++;
    if (obs_vec() !== 16'h0) begin
      n_fail++; $display("FAIL midrst_async got=%h want=%h", obs_vec(), 16'h0);
    end
    tick(); tick();
    #3 Reset_Sw = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midrst_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X && first_vx < 0) first_vx = cyc;
    end
    n_tests++;
    if (first_vx <= PER || first_vx > 2 * PER + 4) begin
      n_fail++; $display("FAIL midrst_first got=%0d want=%0d..%0d", first_vx, PER + 1, 2 * PER + 4);
    end
  endtask

  task automatic test_enable_gap();
    int first_vx = -1;
    repeat ($urandom_range(0, PER - 1)) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL engap_pre t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
    end
    Enable = 1'b0;
    repeat (10) begin
      tick();
      n_tests++;
      if ({Valid_X, Valid_Y, Err_X, Err_Y} !== 4'b0 || Duty_X !== 6'd20 || Duty_Y !== 6'd45) begin
        n_fail++; $display("FAIL engap_hold got=%h want=%h", obs_vec(), {6'd20, 6'd45, 4'b0});
      end
    end
    Enable = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL engap_cycle t=%0t got=%h want=%h", $time, obs_vec(), exp_vec());
      end
      if (Valid_X && first_vx < 0) begin
        first_vx = cyc;
        n_tests++;
        if (Duty_X !== 6'd20) begin
          n_fail++; $display("FAIL engap_duty got=%0d want=20", Duty_X);
        end
      end
    end
    n_tests++;
    if (first_vx < PER || first_vx > 2 * PER + 4) begin
      n_fail++; $display("FAIL engap_first got=%0d want=%0d..%0d", first_vx, PER, 2 * PER + 4);
    end
  endtask

  task automatic test_random();
    int off = 0;
    for (int seg = 0; seg < 12; seg++) begin
      for (int c = 0; c < 2; c++) begin
        int r, per;
        r = $urandom_range(0, 9);
        if (r == 0)      set_stuck(c, 0);
        else if (r == 1) set_stuck(c, 1);
        else begin
          per = (r == 2) ? $urandom_range(40, 90) : PER;
          set_pwm(c, per, $urandom_range(1, per - 1), $urandom_range(0, per - 1));
        end
      end
      repeat (250) begin
        if (off > 0) off--;
        else if ($urandom_range(0, 199) == 0) off = $urandom_range(1, 20);
        Enable = (off == 0);
        tick();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL random_cycle seg=%0d t=%0t got=%h want=%h", seg, $time, obs_vec(), exp_vec());
        end
      end
    end
    Enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck();
    test_bad_period();
    test_duty_change();
    set_pwm(0, PER, 20, 0);
    set_pwm(1, PER, 45, 7);
    test_reset_midperiod();
    test_enable_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
